bsg_cache_store_buffer: RTL and testbench

Two-entry store buffer between the cache's tag-lookup stage and the data-memory write port. Accepts completed store entries (address, data, byte mask, way), holds them until data memory has a free write slot, and drains them in order. A combinational bypass path lets the load pipeline read the newest buffered bytes for a matching word address. Storage is a `bsg_cache_buffer_queue` instance carrying a packed entry.

---
 rtl/bsg_cache_pkg.sv | 27 ++
 rtl/bsg_cache_buffer_queue.sv | 97 +++++++++
 rtl/bsg_cache_store_buffer.sv | 100 ++++++++++
 tb/tb_bsg_cache_store_buffer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_pkg.sv
// Shared store-buffer types: the packed entry layout and its width helpers.
`ifndef BSG_CACHE_PKG_MACROS
`define BSG_CACHE_PKG_MACROS
`define BSG_CACHE_SBUF_ENTRY_WIDTH(addr_w, data_w, lg_ways) \
  ((lg_ways) + (addr_w) + (data_w) + ((data_w) / 8))

`define DECLARE_BSG_CACHE_SBUF_ENTRY_S(addr_w, data_w, lg_ways) \
  typedef struct packed { \
    logic [(lg_ways)-1:0]      way_id; \
    logic [(addr_w)-1:0]       addr; \
    logic [(data_w)-1:0]       data; \
    logic [((data_w)/8)-1:0]   mask; \
  } bsg_cache_sbuf_entry_s
`endif

package bsg_cache_pkg;

  localparam int unsigned sbuf_data_width_lp     = 32;
  localparam int unsigned sbuf_addr_width_lp     = 32;
  localparam int unsigned sbuf_lg_ways_lp        = 1;
  localparam int unsigned lg_data_mask_width_lp  = $clog2(sbuf_data_width_lp / 8);
  localparam int unsigned sbuf_entry_width_lp    =
    `BSG_CACHE_SBUF_ENTRY_WIDTH(sbuf_addr_width_lp, sbuf_data_width_lp, sbuf_lg_ways_lp);

  `DECLARE_BSG_CACHE_SBUF_ENTRY_S(sbuf_addr_width_lp, sbuf_data_width_lp, sbuf_lg_ways_lp);

endpackage

// File: rtl/bsg_cache_buffer_queue.sv
// Two-element in-order queue with zero-latency pass-through when empty; el1 is oldest.
module bsg_cache_buffer_queue
  import bsg_cache_pkg::*;
#(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] el0_snoop_o,
  output logic [width_p-1:0] el1_snoop_o,
  output logic               el0_valid_o,
  output logic               el1_valid_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_n;
  logic               w_el0_we;
  logic               w_el1_we;
  logic               w_el1_from_el0;
  logic [width_p-1:0] r_el0;
  logic [width_p-1:0] r_el1;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_EMPTY;
    else         r_state <= w_state_n;
  end

  // Occupancy transitions; a push+pop on an empty queue drains straight through.
  always_comb begin
    w_state_n      = r_state;
    w_el0_we       = 1'b0;
    w_el1_we       = 1'b0;
    w_el1_from_el0 = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (v_i && !yumi_i) begin
          w_el1_we  = 1'b1;
          w_state_n = ST_ONE;
        end
      end
      ST_ONE: begin
        if (v_i && yumi_i) begin
          w_el1_we = 1'b1;
        end else if (v_i) begin
          w_el0_we  = 1'b1;
          w_state_n = ST_TWO;
        end else if (yumi_i) begin
          w_state_n = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (yumi_i) begin
          w_el1_we       = 1'b1;
          w_el1_from_el0 = 1'b1;
          if (v_i) w_el0_we  = 1'b1;
          else     w_state_n = ST_ONE;
        end
      end
      default: w_state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_el0_we) r_el0 <= data_i;
    if (w_el1_we) r_el1 <= w_el1_from_el0 ? r_el0 : data_i;
  end

  assign empty_o     = (r_state == ST_EMPTY);
  assign full_o      = (r_state == ST_TWO);
  assign el0_valid_o = full_o;
  assign el1_valid_o = !empty_o;
  assign el0_snoop_o = r_el0;
  assign el1_snoop_o = r_el1;
  assign v_o         = empty_o ? v_i : 1'b1;
  assign data_o      = empty_o ? data_i : r_el1;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(v_i && full_o && !yumi_i))
        else $error("bsg_cache_buffer_queue: push while full without pop");
      assert (!(yumi_i && !v_o))
        else $error("bsg_cache_buffer_queue: yumi without valid entry");
    end
  end

endmodule

// File: rtl/bsg_cache_store_buffer.sv
// Two-entry store buffer with newest-first per-byte load bypass.
module bsg_cache_store_buffer
  import bsg_cache_pkg::*;
#(
  parameter  int unsigned data_width_p       = 32,
  parameter  int unsigned addr_width_p       = 32,
  parameter  int unsigned ways_p             = 2,
  localparam int unsigned lg_ways_lp         = (ways_p > 1) ? $clog2(ways_p) : 1,
  localparam int unsigned data_mask_width_lp = data_width_p / 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic [addr_width_p-1:0]       addr_i,
  input  logic [data_width_p-1:0]       data_i,
  input  logic [data_mask_width_lp-1:0] mask_i,
  input  logic [lg_ways_lp-1:0]         way_id_i,
  output logic                          v_o,
  output logic [addr_width_p-1:0]       addr_o,
  output logic [data_width_p-1:0]       data_o,
  output logic [data_mask_width_lp-1:0] mask_o,
  output logic [lg_ways_lp-1:0]         way_id_o,
  input  logic                          yumi_i,
  input  logic                          bypass_v_i,
  input  logic [addr_width_p-1:0]       bypass_addr_i,
  output logic [data_width_p-1:0]       bypass_data_o,
  output logic [data_mask_width_lp-1:0] bypass_mask_o,
  output logic                          empty_o,
  output logic                          full_o
);

  localparam int unsigned lg_mask_lp = $clog2(data_mask_width_lp);

  `DECLARE_BSG_CACHE_SBUF_ENTRY_S(addr_width_p, data_width_p, lg_ways_lp);

  localparam int unsigned entry_width_lp = $bits(bsg_cache_sbuf_entry_s);

  bsg_cache_sbuf_entry_s w_in;
  bsg_cache_sbuf_entry_s w_out;
  bsg_cache_sbuf_entry_s w_el0;
  bsg_cache_sbuf_entry_s w_el1;
  logic                  w_el0_valid;
  logic                  w_el1_valid;

  assign w_in = '{way_id: way_id_i, addr: addr_i, data: data_i, mask: mask_i};

  bsg_cache_buffer_queue #(
    .width_p(entry_width_lp)
  ) u_queue (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .data_i      (w_in),
    .v_o         (v_o),
    .data_o      (w_out),
    .yumi_i      (yumi_i),
    .el0_snoop_o (w_el0),
    .el1_snoop_o (w_el1),
    .el0_valid_o (w_el0_valid),
    .el1_valid_o (w_el1_valid),
    .empty_o     (empty_o),
    .full_o      (full_o)
  );

  assign addr_o   = w_out.addr;
  assign data_o   = w_out.data;
  assign mask_o   = w_out.mask;
  assign way_id_o = w_out.way_id;

  // Word-granular address match for each bypass candidate.
  logic w_in_hit;
  logic w_el0_hit;
  logic w_el1_hit;

  assign w_in_hit  = bypass_v_i && v_i &&
                     (addr_i[addr_width_p-1:lg_mask_lp] == bypass_addr_i[addr_width_p-1:lg_mask_lp]);
  assign w_el0_hit = bypass_v_i && w_el0_valid &&
                     (w_el0.addr[addr_width_p-1:lg_mask_lp] == bypass_addr_i[addr_width_p-1:lg_mask_lp]);
  assign w_el1_hit = bypass_v_i && w_el1_valid &&
                     (w_el1.addr[addr_width_p-1:lg_mask_lp] == bypass_addr_i[addr_width_p-1:lg_mask_lp]);

  for (genvar b = 0; b < data_mask_width_lp; b++) begin : g_byte
    logic w_sel_in;
    logic w_sel_el0;
    logic w_sel_el1;
    assign w_sel_in  = w_in_hit  && mask_i[b];
    assign w_sel_el0 = w_el0_hit && w_el0.mask[b];
    assign w_sel_el1 = w_el1_hit && w_el1.mask[b];
    assign bypass_mask_o[b] = w_sel_in || w_sel_el0 || w_sel_el1;
    assign bypass_data_o[8*b+:8] = w_sel_in  ? data_i[8*b+:8]     :
                                   w_sel_el0 ? w_el0.data[8*b+:8] :
                                   w_sel_el1 ? w_el1.data[8*b+:8] : 8'h00;
  end

  // Byte-offset bits and snooped way ids play no part in forwarding.
  logic w_unused;
  assign w_unused = ^{bypass_addr_i[lg_mask_lp-1:0], w_el0.way_id, w_el1.way_id,
                      w_el0.addr[lg_mask_lp-1:0], w_el1.addr[lg_mask_lp-1:0]};

endmodule

// File: tb/tb_bsg_cache_store_buffer.sv
// Directed bench for bsg_cache_store_buffer: drain order, pass-through, bypass priority, reset.
module tb_bsg_cache_store_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  mask_i;
  logic [0:0]  way_id_i;
  logic        v_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  mask_o;
  logic [0:0]  way_id_o;
  logic        yumi_i;
  logic        bypass_v_i;
  logic [31:0] bypass_addr_i;
  logic [31:0] bypass_data_o;
  logic [3:0]  bypass_mask_o;
  logic        empty_o;
  logic        full_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bsg_cache_store_buffer #(.data_width_p(32), .addr_width_p(32), .ways_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i), .way_id_i(way_id_i),
    .v_o(v_o), .addr_o(addr_o), .data_o(data_o), .mask_o(mask_o), .way_id_o(way_id_o),
    .yumi_i(yumi_i), .bypass_v_i(bypass_v_i), .bypass_addr_i(bypass_addr_i),
    .bypass_data_o(bypass_data_o), .bypass_mask_o(bypass_mask_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic w, input logic y);
    v_i = v; addr_i = a; data_i = d; mask_i = m; way_id_i = w; yumi_i = y;
  endtask

  initial begin
    reset_i = 1'b1; bypass_v_i = 1'b0; bypass_addr_i = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    tick(); tick();
    reset_i = 1'b0;
    bypass_v_i = 1'b1; bypass_addr_i = 32'h100;
    #1;
    chk("reset_empty", 64'(empty_o), 64'h1);
    chk("reset_full",  64'(full_o),  64'h0);
    chk("reset_v_o",   64'(v_o),     64'h0);
    chk("reset_bmask", 64'(bypass_mask_o), 64'h0);
    chk("reset_bdata", 64'(bypass_data_o), 64'h0);
    bypass_v_i = 1'b0;

    // Zero-latency drain through an empty buffer
    drive(1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b1, 1'b1);
    #1;
    chk("pt_v_o",    64'(v_o),      64'h1);
    chk("pt_data_o", 64'(data_o),   64'hAABBCCDD);
    chk("pt_addr_o", 64'(addr_o),   64'h100);
    chk("pt_way_o",  64'(way_id_o), 64'h1);
    chk("pt_mask_o", 64'(mask_o),   64'hF);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("pt_empty_after", 64'(empty_o), 64'h1);
    chk("pt_v_o_after",   64'(v_o),     64'h0);

    // A, B fill; C only with simultaneous yumi; drain A, B, C
    drive(1'b1, 32'h200, 32'hA0A0A0A0, 4'hF, 1'b0, 1'b0);
    #1;
    chk("a_passthru", 64'(data_o), 64'hA0A0A0A0);
    tick();
    drive(1'b1, 32'h204, 32'hB0B0B0B0, 4'h3, 1'b1, 1'b0);
    #1;
    chk("one_empty", 64'(empty_o), 64'h0);
    chk("one_full",  64'(full_o),  64'h0);
    chk("one_head",  64'(data_o),  64'hA0A0A0A0);
    tick();
    drive(1'b1, 32'h208, 32'hC0C0C0C0, 4'hC, 1'b0, 1'b1);
    #1;
    chk("two_full", 64'(full_o), 64'h1);
    chk("two_head", 64'(data_o), 64'hA0A0A0A0);
    chk("two_addr", 64'(addr_o), 64'h200);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    #1;
    chk("c_full",   64'(full_o), 64'h1);
    chk("b_head",   64'(data_o), 64'hB0B0B0B0);
    chk("b_mask",   64'(mask_o), 64'h3);
    chk("b_way",    64'(way_id_o), 64'h1);
    tick();
    #1;
    chk("c_head",   64'(data_o), 64'hC0C0C0C0);
    chk("c_addr",   64'(addr_o), 64'h208);
    chk("c_nfull",  64'(full_o), 64'h0);
    tick();
    yumi_i = 1'b0;
    #1;
    chk("drained_empty", 64'(empty_o), 64'h1);
    chk("drained_v_o",   64'(v_o),     64'h0);

    // Bypass priority: el1 full-word, el0 low half
    drive(1'b1, 32'h100, 32'h11111111, 4'hF, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h100, 32'h22222222, 4'h3, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    bypass_v_i = 1'b1; bypass_addr_i = 32'h102;
    #1;
    chk("byp2_data", 64'(bypass_data_o), 64'h11112222);
    chk("byp2_mask", 64'(bypass_mask_o), 64'hF);
    drive(1'b1, 32'h100, 32'h33000000, 4'h8, 1'b0, 1'b1);
    #1;
    chk("byp3_data", 64'(bypass_data_o), 64'h33112222);
    chk("byp3_mask", 64'(bypass_mask_o), 64'hF);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    bypass_addr_i = 32'h104;
    #1;
    chk("bypmiss_mask", 64'(bypass_mask_o), 64'h0);
    chk("bypmiss_data", 64'(bypass_data_o), 64'h0);
    bypass_v_i = 1'b0; bypass_addr_i = 32'h100;
    #1;
    chk("bypoff_mask", 64'(bypass_mask_o), 64'h0);
    chk("bypoff_data", 64'(bypass_data_o), 64'h0);
    chk("pre_rst_full", 64'(full_o), 64'h1);

    // Reset with a concurrent yumi while full
    reset_i = 1'b1; yumi_i = 1'b1;
    tick();
    reset_i = 1'b0; yumi_i = 1'b0;
    #1;
    chk("rst_empty", 64'(empty_o), 64'h1);
    chk("rst_full",  64'(full_o),  64'h0);
    chk("rst_v_o",   64'(v_o),     64'h0);
    bypass_v_i = 1'b1;
    #1;
    chk("rst_bmask", 64'(bypass_mask_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
